mem_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the shared byte-addressed data/instruction BRAM. It sits between the CPU's instruction-fetch unit and its load/store unit on one side, and the single BRAM port on the other. Requests are granted round-robin, issued as one-cycle BRAM accesses that are stable across the BRAM's negedge sample, and completed with an ack pulse and registered read data. Out-of-range addresses are rejected without touching memory.

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arbiter_rr.sv | 21 ++
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-port BRAM arbiter slice.
package mem_arb_pkg;

    localparam int ADDR_WIDTH_DEF = 32;
    localparam int MEM_DEPTH_DEF  = 2250;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } grant_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, load/store and BRAM signals around the arbiter.
interface mem_arbiter_if import mem_arb_pkg::*; #(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_ack;
    logic [ADDR_WIDTH-1:0] if_rdata;
    logic                  if_err;

    logic                  d_req;
    logic                  d_write;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [ADDR_WIDTH-1:0] d_wdata;
    logic                  d_ack;
    logic [ADDR_WIDTH-1:0] d_rdata;
    logic                  d_err;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_wdata;
    logic [ADDR_WIDTH-1:0] mem_rdata;
    logic                  busy;

    // Requesters and BRAM side.
    modport master (
        output if_req, if_addr, d_req, d_write, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
        input  mem_addr, mem_write, mem_wdata, busy
    );

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, d_req, d_write, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
        output mem_addr, mem_write, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter_rr.sv
// Combinational two-way round-robin picker; the caller owns last_grant.
module rr_arbiter2 import mem_arb_pkg::*; (
    input  logic [1:0] req,
    input  grant_e     last_grant,
    output grant_e     grant,
    output logic       valid
);

    // Single requester wins outright; on contention the port not served last wins.
    always_comb begin
        valid = |req;
        grant = GNT_IF;
        case (req)
            2'b01:   grant = GNT_IF;
            2'b10:   grant = GNT_D;
            2'b11:   grant = (last_grant == GNT_IF) ? GNT_D : GNT_IF;
            default: grant = GNT_IF;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and one-cycle access sequencer between fetch,
// load/store and a single negedge-sampling BRAM port.
module mem_arbiter import mem_arb_pkg::*; #(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int MEM_DEPTH  = MEM_DEPTH_DEF
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    localparam int ADDR_EXT = ADDR_WIDTH + 1;

    state_e                state_r;
    grant_e                last_grant_r;
    grant_e                cur_grant_r;
    logic                  err_pend_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic                  mem_write_r;
    logic [ADDR_WIDTH-1:0] mem_wdata_r;
    logic                  busy_r;
    logic                  if_ack_r;
    logic [ADDR_WIDTH-1:0] if_rdata_r;
    logic                  if_err_r;
    logic                  d_ack_r;
    logic [ADDR_WIDTH-1:0] d_rdata_r;
    logic                  d_err_r;

    logic [1:0]            req_s;
    grant_e                pick_s;
    logic                  pick_valid_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic                  sel_write_s;
    logic [ADDR_WIDTH-1:0] sel_wdata_s;
    logic [ADDR_WIDTH:0]   sel_end_s;
    logic                  in_range_s;
    logic [ADDR_WIDTH-1:0] rd_word_s;

    // Requests eligible for a grant; in DONE the port just acked sits out one cycle.
    always_comb begin
        req_s = 2'b00;
        case (state_r)
            ST_IDLE: req_s = {bus.d_req, bus.if_req};
            ST_DONE: begin
                if (cur_grant_r == GNT_IF) begin
                    req_s = {bus.d_req, 1'b0};
                end else begin
                    req_s = {1'b0, bus.if_req};
                end
            end
            default: req_s = 2'b00;
        endcase
    end

    rr_arbiter2 u_rr (
        .req        (req_s),
        .last_grant (last_grant_r),
        .grant      (pick_s),
        .valid      (pick_valid_s)
    );

    // Winner's request fields; fetch is always a read with no write data.
    always_comb begin
        sel_addr_s  = bus.if_addr;
        sel_write_s = 1'b0;
        sel_wdata_s = {ADDR_WIDTH{1'b0}};
        case (pick_s)
            GNT_D: begin
                sel_addr_s  = bus.d_addr;
                sel_write_s = bus.d_write;
                sel_wdata_s = bus.d_wdata;
            end
            default: begin
                sel_addr_s  = bus.if_addr;
                sel_write_s = 1'b0;
                sel_wdata_s = {ADDR_WIDTH{1'b0}};
            end
        endcase
    end

    // Extra top bit keeps addresses near the top of the space from wrapping into range.
    assign sel_end_s  = {1'b0, sel_addr_s} + ADDR_EXT'(3);
    assign in_range_s = (sel_end_s < ADDR_EXT'(MEM_DEPTH));

    // Stores and rejected accesses return a zero word.
    always_comb begin
        if (mem_write_r || err_pend_r) begin
            rd_word_s = {ADDR_WIDTH{1'b0}};
        end else begin
            rd_word_s = bus.mem_rdata;
        end
    end

    // Sequencer: grant -> one BRAM cycle -> ack, with back-to-back grant from DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            last_grant_r <= GNT_D;
            cur_grant_r  <= GNT_IF;
            err_pend_r   <= 1'b0;
            mem_addr_r   <= {ADDR_WIDTH{1'b0}};
            mem_write_r  <= 1'b0;
            mem_wdata_r  <= {ADDR_WIDTH{1'b0}};
            busy_r       <= 1'b0;
            if_ack_r     <= 1'b0;
            if_rdata_r   <= {ADDR_WIDTH{1'b0}};
            if_err_r     <= 1'b0;
            d_ack_r      <= 1'b0;
            d_rdata_r    <= {ADDR_WIDTH{1'b0}};
            d_err_r      <= 1'b0;
        end else begin
            if_ack_r <= 1'b0;
            d_ack_r  <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (pick_valid_s) begin
                        state_r     <= ST_ACCESS;
                        busy_r      <= 1'b1;
                        cur_grant_r <= pick_s;
                        err_pend_r  <= ~in_range_s;
                        mem_addr_r  <= in_range_s ? sel_addr_s : {ADDR_WIDTH{1'b0}};
                        mem_write_r <= in_range_s & sel_write_s;
                        mem_wdata_r <= sel_wdata_s;
                        if (pick_s == GNT_IF) begin
                            if_err_r <= 1'b0;
                        end else begin
                            d_err_r  <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    state_r      <= ST_DONE;
                    busy_r       <= 1'b0;
                    mem_write_r  <= 1'b0;
                    last_grant_r <= cur_grant_r;
                    if (cur_grant_r == GNT_IF) begin
                        if_ack_r   <= 1'b1;
                        if_rdata_r <= rd_word_s;
                        if_err_r   <= err_pend_r;
                    end else begin
                        d_ack_r    <= 1'b1;
                        d_rdata_r  <= rd_word_s;
                        d_err_r    <= err_pend_r;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    busy_r      <= 1'b0;
                    mem_write_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_write = mem_write_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.busy      = busy_r;
    assign bus.if_ack    = if_ack_r;
    assign bus.if_rdata  = if_rdata_r;
    assign bus.if_err    = if_err_r;
    assign bus.d_ack     = d_ack_r;
    assign bus.d_rdata   = d_rdata_r;
    assign bus.d_err     = d_err_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-array BRAM model sampling on negedge.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int DEPTH = 2250;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   wr_count = 0;
    logic mem_init = 1'b0;
    logic [7:0] mem [0:DEPTH-1];

    mem_arbiter_if #(.ADDR_WIDTH(32)) bus ();

    mem_arbiter #(.ADDR_WIDTH(32), .MEM_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // BRAM model: big-endian word, write and read registered on negedge.
    always @(negedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'hA5;
            mem[16] <= 8'h11; mem[17] <= 8'h22; mem[18] <= 8'h33; mem[19] <= 8'h44;
            mem_init <= 1'b1;
        end else if (bus.mem_write === 1'b1 && bus.mem_addr + 32'd3 < DEPTH) begin
            mem[bus.mem_addr]     <= bus.mem_wdata[31:24];
            mem[bus.mem_addr + 1] <= bus.mem_wdata[23:16];
            mem[bus.mem_addr + 2] <= bus.mem_wdata[15:8];
            mem[bus.mem_addr + 3] <= bus.mem_wdata[7:0];
        end
        if ({1'b0, bus.mem_addr} + 33'd3 < 33'(DEPTH)) begin
            bus.mem_rdata <= {mem[bus.mem_addr], mem[bus.mem_addr + 1],
                              mem[bus.mem_addr + 2], mem[bus.mem_addr + 3]};
        end else begin
            bus.mem_rdata <= 32'hBAD0BAD0;
        end
    end

    // Counts cycles with the BRAM write enable high.
    always @(posedge clk) begin
        if (bus.mem_write === 1'b1) wr_count <= wr_count + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input int a);
        return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
    endfunction

    // One complete handshake on a single port, bounded wait for the ack.
    task automatic access(input bit port_d, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input string tag);
        int   cyc;
        int   w0;
        logic got;
        if (port_d) begin
            bus.d_req = 1'b1; bus.d_write = wr; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end
        w0  = wr_count;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 10) begin
            step();
            cyc++;
            got = port_d ? bus.d_ack : bus.if_ack;
        end
        check({tag, "_latency"}, 32'(cyc), 32'd2);
        check({tag, "_rdata"}, port_d ? bus.d_rdata : bus.if_rdata, exp_rdata);
        check({tag, "_err"}, {31'd0, port_d ? bus.d_err : bus.if_err}, {31'd0, exp_err});
        check({tag, "_other_ack"}, {31'd0, port_d ? bus.if_ack : bus.d_ack}, 32'd0);
        check({tag, "_wr_cycles"}, 32'(wr_count - w0), (wr && !exp_err) ? 32'd1 : 32'd0);
        if (port_d) bus.d_req = 1'b0; else bus.if_req = 1'b0;
        step();
        check({tag, "_ack_pulse"}, {31'd0, port_d ? bus.d_ack : bus.if_ack}, 32'd0);
    endtask

    initial begin
        bus.if_req = 1'b0; bus.if_addr = 32'd0;
        bus.d_req = 1'b0; bus.d_write = 1'b0; bus.d_addr = 32'd0; bus.d_wdata = 32'd0;

        // Reset state
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_acks", {30'd0, bus.if_ack, bus.d_ack}, 32'd0);
        check("rst_errs", {30'd0, bus.if_err, bus.d_err}, 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_write", {31'd0, bus.mem_write}, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_if_rdata", bus.if_rdata, 32'd0);
        check("rst_d_rdata", bus.d_rdata, 32'd0);

        // Single load, then store and fetch back
        access(1'b1, 1'b0, 32'h10, 32'd0, 32'h11223344, 1'b0, "load10");
        access(1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 32'd0, 1'b0, "store20");
        check("mem20", word_at(32), 32'hDEADBEEF);
        access(1'b0, 1'b0, 32'h20, 32'd0, 32'hDEADBEEF, 1'b0, "fetch20");

        // Range boundary: 2247 rejected, 2246 accepted
        access(1'b1, 1'b1, 32'd2247, 32'h12345678, 32'd0, 1'b1, "store2247");
        check("mem2246_kept", word_at(2246), 32'hA5A5A5A5);
        check("mem0_kept", word_at(0), 32'hA5A5A5A5);
        access(1'b1, 1'b1, 32'd2246, 32'h01020304, 32'd0, 1'b0, "store2246");
        check("mem2246_new", word_at(2246), 32'h01020304);
        access(1'b1, 1'b0, 32'd2246, 32'd0, 32'h01020304, 1'b0, "load2246");

        // Address near the top of the space must not wrap into low memory
        access(1'b0, 1'b0, 32'hFFFFFFFE, 32'd0, 32'd0, 1'b1, "fetch_wrap");

        // Contention from reset: IF, D, IF, D with an ack every other cycle
        rst = 1'b1;
        bus.if_req = 1'b1; bus.if_addr = 32'h20;
        bus.d_req = 1'b1; bus.d_write = 1'b0; bus.d_addr = 32'h10;
        step();
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("cont%0d_if_ack", k), {31'd0, bus.if_ack},
                  (k == 2 || k == 6) ? 32'd1 : 32'd0);
            check($sformatf("cont%0d_d_ack", k), {31'd0, bus.d_ack},
                  (k == 4 || k == 8) ? 32'd1 : 32'd0);
            check($sformatf("cont%0d_busy", k), {31'd0, bus.busy}, 32'(k % 2));
            if (k == 2 || k == 6) check($sformatf("cont%0d_if_rdata", k), bus.if_rdata, 32'hDEADBEEF);
            if (k == 4 || k == 8) check($sformatf("cont%0d_d_rdata", k), bus.d_rdata, 32'h11223344);
        end
        check("cont_if_err", {31'd0, bus.if_err}, 32'd0);
        bus.if_req = 1'b0;
        bus.d_req = 1'b0;
        step();
        check("cont_end_busy", {31'd0, bus.busy}, 32'd0);
        check("cont_end_acks", {30'd0, bus.if_ack, bus.d_ack}, 32'd0);

        // Reset during the ACCESS cycle of a load
        bus.d_req = 1'b1; bus.d_write = 1'b0; bus.d_addr = 32'h10;
        step();
        check("rma_busy_pre", {31'd0, bus.busy}, 32'd1);
        check("rma_mem_addr_pre", bus.mem_addr, 32'h10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rma_busy", {31'd0, bus.busy}, 32'd0);
        check("rma_d_ack", {31'd0, bus.d_ack}, 32'd0);
        check("rma_mem_addr", bus.mem_addr, 32'd0);
        check("rma_d_rdata", bus.d_rdata, 32'd0);
        check("rma_if_rdata", bus.if_rdata, 32'd0);
        access(1'b1, 1'b0, 32'h10, 32'd0, 32'h11223344, 1'b0, "rma_reload");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
